// File: rtl/fp_div.sv
// IEEE-754 single-precision divider: 26-cycle restoring significand division,
// round-to-nearest-even, flush-to-zero inputs, no subnormal outputs.
module fp_div #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [XLEN-1:0] in1,
    input  logic [XLEN-1:0] in2,
    output logic [XLEN-1:0] result,
    output logic            busy,
    output logic            done,
    output logic            overflow,
    output logic            underflow,
    output logic            div_by_zero,
    output logic            invalid
);
    // state | meaning
    // IDLE  | waiting for start; operands captured and classified on start
    // DIV   | one restoring-division step per cycle, 26 cycles
    // ROUND | normalise, round to nearest even, range check
    // DONE  | one-cycle done pulse
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DIV   = 2'd1;
    localparam logic [1:0] ROUND = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]        state;
    logic [4:0]        cnt;
    logic              sign_r;
    logic signed [9:0] exp_r;
    logic [24:0]       rem_r;
    logic [23:0]       mb_r;
    logic [25:0]       q_r;

    logic [7:0]  ea, eb;
    logic        z1, z2, inf1, inf2, nan1, nan2, sign_q;
    logic        spec_hit, spec_inv, spec_dbz;
    logic [31:0] spec_res;
    logic signed [9:0] e_init;

    always_comb begin
        ea     = in1[30:23];
        eb     = in2[30:23];
        z1     = (ea == 8'd0);
        z2     = (eb == 8'd0);
        inf1   = (ea == 8'hFF) && (in1[22:0] == 23'd0);
        inf2   = (eb == 8'hFF) && (in2[22:0] == 23'd0);
        nan1   = (ea == 8'hFF) && (in1[22:0] != 23'd0);
        nan2   = (eb == 8'hFF) && (in2[22:0] != 23'd0);
        sign_q = in1[31] ^ in2[31];
        e_init = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd127;
        spec_hit = 1'b1;
        spec_inv = 1'b0;
        spec_dbz = 1'b0;
        spec_res = 32'd0;
        if (nan1 || nan2) begin
            spec_res = 32'h7FC00000;
        end else if ((z1 && z2) || (inf1 && inf2)) begin
            spec_res = 32'h7FC00000;
            spec_inv = 1'b1;
        end else if (inf1) begin
            spec_res = {sign_q, 8'hFF, 23'd0};
        end else if (inf2 || z1) begin
            spec_res = {sign_q, 31'd0};
        end else if (z2) begin
            spec_res = {sign_q, 8'hFF, 23'd0};
            spec_dbz = 1'b1;
        end else begin
            spec_hit = 1'b0;
        end
    end

    logic [25:0] diff;
    logic        q_bit;
    logic [24:0] rem_next;

    always_comb begin
        diff     = {1'b0, rem_r} - {2'b00, mb_r};
        q_bit    = ~diff[25];
        rem_next = q_bit ? {diff[23:0], 1'b0} : {rem_r[23:0], 1'b0};
    end

    // Quotient lies in [2^24, 2^26); normalise so the leading one sits at bit 25.
    logic [25:0]       norm;
    logic signed [9:0] e1, e2;
    logic [23:0]       sig, sig2;
    logic              guard, sticky, round_up;
    logic [24:0]       sum;
    logic [31:0]       round_res;
    logic              round_ovf, round_unf;

    always_comb begin
        norm     = q_r[25] ? q_r : (q_r << 1);
        e1       = q_r[25] ? exp_r : exp_r - 10'sd1;
        sig      = norm[25:2];
        guard    = norm[1];
        sticky   = norm[0] | (rem_r != 25'd0);
        round_up = guard & (sticky | sig[0]);
        sum      = {1'b0, sig} + {24'd0, round_up};
        sig2     = sum[24] ? sum[24:1] : sum[23:0];
        e2       = sum[24] ? e1 + 10'sd1 : e1;
        round_ovf = 1'b0;
        round_unf = 1'b0;
        if (e2 >= 10'sd255) begin
            round_res = {sign_r, 8'hFF, 23'd0};
            round_ovf = 1'b1;
        end else if (e2 <= 10'sd0) begin
            round_res = {sign_r, 31'd0};
            round_unf = 1'b1;
        end else begin
            round_res = {sign_r, e2[7:0], sig2[22:0]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= 5'd0;
            sign_r      <= 1'b0;
            exp_r       <= 10'sd0;
            rem_r       <= 25'd0;
            mb_r        <= 24'd0;
            q_r         <= 26'd0;
            result      <= 32'd0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
            div_by_zero <= 1'b0;
            invalid     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sign_r      <= sign_q;
                        exp_r       <= e_init;
                        rem_r       <= {2'b01, in1[22:0]};
                        mb_r        <= {1'b1, in2[22:0]};
                        q_r         <= 26'd0;
                        cnt         <= 5'd25;
                        overflow    <= 1'b0;
                        underflow   <= 1'b0;
                        div_by_zero <= spec_hit & spec_dbz;
                        invalid     <= spec_hit & spec_inv;
                        result      <= spec_hit ? spec_res : 32'd0;
                        state       <= spec_hit ? DONE : DIV;
                    end
                end
                DIV: begin
                    rem_r <= rem_next;
                    q_r   <= {q_r[24:0], q_bit};
                    if (cnt == 5'd0) state <= ROUND;
                    else cnt <= cnt - 5'd1;
                end
                ROUND: begin
                    result    <= round_res;
                    overflow  <= round_ovf;
                    underflow <= round_unf;
                    state     <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == DIV) || (state == ROUND);
    assign done = (state == DONE);
endmodule

// File: tb/tb_fp_div.sv
// Directed self-checking bench for fp_div: normal quotients, special cases,
// range limits, mid-operation reset and start-while-busy behaviour.
module tb_fp_div;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] in1 = 32'd0;
    logic [31:0] in2 = 32'd0;
    logic [31:0] result;
    logic        busy, done, overflow, underflow, div_by_zero, invalid;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int lat;
    int busy_err;
    int n_done;

    fp_div #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .start(start), .in1(in1), .in2(in2),
        .result(result), .busy(busy), .done(done), .overflow(overflow),
        .underflow(underflow), .div_by_zero(div_by_zero), .invalid(invalid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] flags();
        return {28'd0, overflow, underflow, div_by_zero, invalid};
    endfunction

    // Drives a one-cycle start; lat = cycle (after start edge) in which done is seen, 0 on timeout.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        in1 = a; in2 = b; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0;
        busy_err = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (done) begin
                lat = k;
                if (busy) busy_err++;
                break;
            end
            if (!busy) busy_err++;
        end
    endtask

    task automatic check_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp_res, input logic [3:0] exp_flags,
                            input int exp_lat);
        run_op(a, b);
        chk({tag, "_result"}, result, exp_res);
        chk({tag, "_flags"}, flags(), {28'd0, exp_flags});
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_busy"}, busy_err, 0);
        @(negedge clk);
        chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1;
        chk("reset_result", result, 32'd0);
        chk("reset_ctrl", {30'd0, busy, done}, 32'd0);
        chk("reset_flags", flags(), 32'd0);
        rst = 1'b0;

        // flags = {overflow, underflow, div_by_zero, invalid}
        check_op("six_by_two",  32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 28);
        check_op("one_third",   32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'b0000, 28);
        check_op("neg_ten",     32'hC1200000, 32'h40200000, 32'hC0800000, 4'b0000, 28);
        check_op("one_by_zero", 32'h3F800000, 32'h00000000, 32'h7F800000, 4'b0010, 1);
        check_op("zero_zero",   32'h00000000, 32'h00000000, 32'h7FC00000, 4'b0001, 1);
        check_op("nan_in",      32'h7FC00000, 32'h3F800000, 32'h7FC00000, 4'b0000, 1);
        check_op("inf_by_x",    32'h7F800000, 32'hBF800000, 32'hFF800000, 4'b0000, 1);
        check_op("x_by_inf",    32'h3F800000, 32'hFF800000, 32'h80000000, 4'b0000, 1);
        check_op("overflow",    32'h7F7FFFFF, 32'h3E800000, 32'h7F800000, 4'b1000, 28);
        check_op("underflow",   32'h00800000, 32'h40000000, 32'h00000000, 4'b0100, 28);
        check_op("underflow_n", 32'h80800000, 32'h40000000, 32'h80000000, 4'b0100, 28);

        // Reset in DIV cycle 10 of 6.0/2.0
        @(negedge clk);
        in1 = 32'h40C00000; in2 = 32'h40000000; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_outputs", result, 32'd0);
        chk("midrst_ctrl", {28'd0, busy, done, 2'b00} | flags(), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) n_done++;
        end
        chk("midrst_no_done", n_done, 0);
        check_op("after_rst", 32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 28);

        // start pulses while busy and in the DONE cycle are ignored
        @(negedge clk);
        in1 = 32'h40C00000; in2 = 32'h40000000; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n_done = 0;
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (done) begin
                n_done++;
                if (lat == 0) lat = k;
            end
            if (k == 5 || done) begin
                in1 = 32'h3F800000; in2 = 32'h00000000; start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        chk("busy_start_result", result, 32'h40400000);
        chk("busy_start_flags", flags(), 32'd0);
        chk("busy_start_ndone", n_done, 1);
        chk("busy_start_latency", lat, 28);
        chk("busy_start_idle", {31'd0, busy}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
